// File: rtl/dig_display_arbiter.sv
// Two-requester arbiter for the seven-segment display write port.
// Each grant yields one write strobe, then the owner holds the display for HOLD_CYCLES.
module dig_display_arbiter #(
   parameter logic [31:0] DIG_ADDR    = 32'hFFFF_F000,
   parameter int          HOLD_CYCLES = 20000,
   parameter int          HOLD_WIDTH  = 20
) (
   input  logic        clk_from_bg,
   input  logic        rst_from_bg,
   input  logic        req0_valid,
   input  logic [31:0] req0_data,
   output logic        req0_ready,
   input  logic        req1_valid,
   input  logic [31:0] req1_data,
   output logic        req1_ready,
   output logic [31:0] dig_addr_2_bg,
   output logic        dig_we_2_bg,
   output logic [31:0] dig_wdata_2_bg,
   output logic        owner,
   output logic        busy
);

   typedef enum logic [1:0] {
      IDLE,
      WRITE,
      HOLD
   } state_t;

   localparam logic [HOLD_WIDTH-1:0] HOLD_LAST = HOLD_WIDTH'(HOLD_CYCLES - 1);

   state_t                state_q, state_d;
   logic [31:0]           wdata_q, wdata_d;
   logic                  owner_q, owner_d;
   logic                  rrPtr_q, rrPtr_d;
   logic [HOLD_WIDTH-1:0] holdCnt_q, holdCnt_d;
   logic                  we_q;
   logic                  busy_q;
   logic                  grant0;
   logic                  grant1;

   // Arbitration and sequencing; in HOLD only the current owner may refresh its value
   always_comb begin
      state_d   = state_q;
      wdata_d   = wdata_q;
      owner_d   = owner_q;
      rrPtr_d   = rrPtr_q;
      holdCnt_d = holdCnt_q;
      grant0    = 1'b0;
      grant1    = 1'b0;
      case (state_q)
         IDLE: begin
            if (req0_valid && (!req1_valid || !rrPtr_q)) begin
               grant0 = 1'b1;
            end else if (req1_valid) begin
               grant1 = 1'b1;
            end
            if (grant0 || grant1) begin
               wdata_d = grant1 ? req1_data : req0_data;
               owner_d = grant1;
               rrPtr_d = ~grant1;
               state_d = WRITE;
            end
         end
         WRITE: begin
            holdCnt_d = '0;
            state_d   = HOLD;
         end
         HOLD: begin
            holdCnt_d = holdCnt_q + HOLD_WIDTH'(1);
            grant0    = !owner_q && req0_valid;
            grant1    = owner_q && req1_valid;
            if (grant0 || grant1) begin
               wdata_d = owner_q ? req1_data : req0_data;
               state_d = WRITE;
            end else if (holdCnt_q == HOLD_LAST) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Strobe and busy are registered from the next state so every output but ready is a flop
   always_ff @(posedge clk_from_bg or posedge rst_from_bg) begin
      if (rst_from_bg) begin
         state_q   <= IDLE;
         wdata_q   <= '0;
         owner_q   <= 1'b0;
         rrPtr_q   <= 1'b0;
         holdCnt_q <= '0;
         we_q      <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         wdata_q   <= wdata_d;
         owner_q   <= owner_d;
         rrPtr_q   <= rrPtr_d;
         holdCnt_q <= holdCnt_d;
         we_q      <= (state_d == WRITE);
         busy_q    <= (state_d != IDLE);
      end
   end

   assign req0_ready     = grant0 && !rst_from_bg;
   assign req1_ready     = grant1 && !rst_from_bg;
   assign dig_addr_2_bg  = DIG_ADDR;
   assign dig_we_2_bg    = we_q;
   assign dig_wdata_2_bg = wdata_q;
   assign owner          = owner_q;
   assign busy           = busy_q;

endmodule
